// File: rtl/rptr_empty_fwft_if.sv
// rptr_empty_fwft_if: read-side FIFO controller bundle (memory port, pointers, flags, FWFT handshake)
interface rptr_empty_fwft_if #(
   parameter int ASIZE = 4,
   parameter int DSIZE = 8
);
   logic [ASIZE:0]   wr_ptr;
   logic [ASIZE-1:0] rd_addr;
   logic             rd_en_mem;
   logic [DSIZE-1:0] mem_rdata;
   logic [ASIZE:0]   rd_ptr;
   logic             rd_empty;
   logic [ASIZE:0]   rd_level;
   logic             rd_almost_empty;
   logic             rd_valid;
   logic [DSIZE-1:0] rd_data;
   logic             rd_ready;
   modport master (
      input  wr_ptr, mem_rdata, rd_ready,
      output rd_addr, rd_en_mem, rd_ptr, rd_empty, rd_level, rd_almost_empty, rd_valid, rd_data
   );
   modport slave (
      output wr_ptr, mem_rdata, rd_ready,
      input  rd_addr, rd_en_mem, rd_ptr, rd_empty, rd_level, rd_almost_empty, rd_valid, rd_data
   );
endinterface

// File: rtl/rptr_empty_fwft.sv
// rptr_empty_fwft: read-domain pointer, empty/level flags and 2-entry first-word-fall-through buffer
module rptr_empty_fwft #(
   parameter int ASIZE     = 4,
   parameter int DSIZE     = 8,
   parameter int AE_THRESH = 2
) (
   input logic               rd_clk,
   input logic               rd_rst,
   rptr_empty_fwft_if.master bus
);
   localparam logic [ASIZE:0] AE = (ASIZE+1)'(AE_THRESH);
   logic [ASIZE:0]   r_sync1, r_sync2, r_rbin, r_rptr, r_level;
   logic             r_empty, r_ae, r_infl;
   logic [1:0]       r_cnt;
   logic [DSIZE-1:0] r_head, r_tail;
   logic             w_pop, w_inc;
   logic [1:0]       w_occ;
   logic [ASIZE:0]   w_rbnext, w_rgnext, w_wbin, w_diff;
   // issue a memory read only while the buffer plus the word in flight leaves room after this cycle's pop
   always_comb begin
      w_pop    = (r_cnt != 2'd0) & bus.rd_ready;
      w_occ    = r_cnt + {1'b0, r_infl};
      w_inc    = !r_empty & ((w_occ - {1'b0, w_pop}) < 2'd2);
      w_rbnext = r_rbin + {{ASIZE{1'b0}}, w_inc};
      w_rgnext = (w_rbnext >> 1) ^ w_rbnext;
      w_wbin   = '0;
      for (int i = 0; i <= ASIZE; i++) w_wbin[i] = ^(r_sync2 >> i);
      w_diff   = w_wbin - w_rbnext;
   end
   // synchronise the write pointer, advance the read pointer and register the flags from the same next pointer
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_rbin  <= '0;
         r_rptr  <= '0;
         r_empty <= 1'b1;
         r_level <= '0;
         r_ae    <= 1'b1;
         r_infl  <= 1'b0;
      end else begin
         r_sync1 <= bus.wr_ptr;
         r_sync2 <= r_sync1;
         r_rbin  <= w_rbnext;
         r_rptr  <= w_rgnext;
         r_empty <= (w_rgnext == r_sync2);
         r_level <= w_diff;
         r_ae    <= (w_diff <= AE);
         r_infl  <= w_inc;
      end
   end
   // output buffer: head/tail pair, the word returning from memory lands behind whatever is not popped
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
         if (w_pop && r_cnt == 2'd2) r_head <= r_tail;
         else if (r_infl && (w_pop ? r_cnt == 2'd1 : r_cnt == 2'd0)) r_head <= bus.mem_rdata;
         if (r_infl && (w_pop ? r_cnt == 2'd2 : r_cnt == 2'd1)) r_tail <= bus.mem_rdata;
      end
   end
   assign bus.rd_addr         = r_rbin[ASIZE-1:0];
   assign bus.rd_en_mem       = w_inc;
   assign bus.rd_ptr          = r_rptr;
   assign bus.rd_empty        = r_empty;
   assign bus.rd_level        = r_level;
   assign bus.rd_almost_empty = r_ae;
   assign bus.rd_valid        = (r_cnt != 2'd0);
   assign bus.rd_data         = r_head;
endmodule

// File: tb/tb_rptr_empty_fwft.sv
// tb_rptr_empty_fwft: directed plan plus randomized traffic checked against a word-count reference model
module tb_rptr_empty_fwft;
   localparam int AS = 4, DS = 8, AE = 2;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   rptr_empty_fwft_if #(.ASIZE(AS), .DSIZE(DS)) bus ();
   rptr_empty_fwft #(.ASIZE(AS), .DSIZE(DS), .AE_THRESH(AE)) dut (.rd_clk(clk), .rd_rst(rst), .bus(bus));

   int checks = 0, errors = 0;
   logic [7:0] mem [16];
   logic [7:0] wlog [4096];
   int wcnt = 0;

   always @(posedge clk) if (bus.rd_en_mem === 1'b1) bus.mem_rdata <= mem[bus.rd_addr];

   function automatic logic [4:0] g(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [4:0] b2(input logic [4:0] gv);
      logic [4:0] r;
      r[4] = gv[4];
      for (int i = 3; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr1(input logic [7:0] d);
      mem[wcnt[3:0]] = d;
      wlog[wcnt[11:0]] = d;
      wcnt++;
      bus.wr_ptr = g(wcnt[4:0]);
   endtask
   task automatic write_to(input int n);
      while (wcnt < n) wr1(8'hA0 + 8'(wcnt));
   endtask

   // reference model: counts of words issued, arrived and popped since reset
   logic m_ok = 1'b0, m_empty, m_ae;
   logic [4:0] m_s1, m_s2, m_lvl;
   int iss, arr, popd;
   always @(negedge clk) begin
      logic ev, pop, ei;
      ev  = (arr - popd) > 0;
      pop = ev && bus.rd_ready;
      ei  = !m_empty && (iss - popd - int'(pop)) < 2;
      if (m_ok) begin
         chk("m_rd_ptr", bus.rd_ptr, g(iss[4:0]));
         chk("m_rd_empty", bus.rd_empty, m_empty);
         chk("m_rd_level", bus.rd_level, m_lvl);
         chk("m_rd_almost_empty", bus.rd_almost_empty, m_ae);
         chk("m_rd_valid", bus.rd_valid, ev);
         if (ev) chk("m_rd_data", bus.rd_data, wlog[popd % 4096]);
         chk("m_rd_en_mem", bus.rd_en_mem, ei);
         if (ei) chk("m_rd_addr", bus.rd_addr, iss % 16);
      end
      if (rst) begin
         m_ok = 1'b1; m_s1 = '0; m_s2 = '0; iss = 0; arr = 0; popd = 0;
         m_lvl = '0; m_empty = 1'b1; m_ae = 1'b1;
      end else if (m_ok) begin
         popd += int'(pop);
         arr = iss;
         iss += int'(ei);
         m_lvl = b2(m_s2) - iss[4:0];
         m_empty = (m_lvl == 5'd0);
         m_ae = (m_lvl <= AE);
         m_s2 = m_s1;
         m_s1 = bus.wr_ptr;
      end
   end

   // per-test capture of read issues and accepted words
   int aq[$], acyc[$], dq[$], dcyc[$];
   int cyc = 0;
   logic got16;
   logic [4:0] p16;
   task automatic clearq();
      aq.delete(); acyc.delete(); dq.delete(); dcyc.delete(); got16 = 1'b0; p16 = '0;
   endtask
   task automatic step(input int wlim);
      logic [4:0] fl;
      @(negedge clk);
      if (aq.size() == 16 && !got16) begin p16 = bus.rd_ptr; got16 = 1'b1; end
      if (bus.rd_en_mem) begin aq.push_back(int'(bus.rd_addr)); acyc.push_back(cyc); end
      if (bus.rd_valid && bus.rd_ready) begin dq.push_back(int'(bus.rd_data)); dcyc.push_back(cyc); end
      cyc++;
      @(posedge clk); #1;
      fl = wcnt[4:0] - b2(bus.rd_ptr);
      if (wcnt < wlim && fl < 5'd16) wr1(8'hA0 + 8'(wcnt));
   endtask
   task automatic reset_all();
      rst = 1'b1; wcnt = 0; bus.wr_ptr = '0; bus.rd_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int n, rp, wp;
      logic [4:0] fl;
      bus.wr_ptr = '0;
      bus.rd_ready = 1'b0;
      // reset held two edges with a write pointer of four words already visible
      @(posedge clk); #1;
      write_to(4);
      chk("t1_rst_empty", bus.rd_empty, 1);
      chk("t1_rst_valid", bus.rd_valid, 0);
      chk("t1_rst_ptr", bus.rd_ptr, 0);
      chk("t1_rst_level", bus.rd_level, 0);
      chk("t1_rst_ae", bus.rd_almost_empty, 1);
      chk("t1_rst_data", bus.rd_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         n++;
         if (!bus.rd_empty) break;
      end
      chk("t1_empty_latency", n, 3);
      chk("t1_level", bus.rd_level, 4);
      // fall-through of three words
      reset_all();
      write_to(3);
      bus.rd_ready = 1'b1;
      clearq();
      repeat (12) step(0);
      chk("t2_issues", aq.size(), 3);
      for (int i = 0; i < 3; i++) chk("t2_addr", aq[i], i);
      chk("t2_issue_span", acyc[2] - acyc[0], 2);
      chk("t2_words", dq.size(), 3);
      for (int i = 0; i < 3; i++) chk("t2_data", dq[i], 32'hA0 + i);
      chk("t2_data_span", dcyc[2] - dcyc[0], 2);
      chk("t2_first_latency", dcyc[0] - acyc[0], 2);
      chk("t2_empty", bus.rd_empty, 1);
      chk("t2_ptr", bus.rd_ptr, 5'b00010);
      // backpressure: only two words fetched, head held
      reset_all();
      write_to(5);
      clearq();
      repeat (10) step(0);
      chk("t3_issues", aq.size(), 2);
      chk("t3_valid", bus.rd_valid, 1);
      chk("t3_data", bus.rd_data, 8'hA0);
      chk("t3_level", bus.rd_level, 3);
      chk("t3_ae", bus.rd_almost_empty, 0);
      bus.rd_ready = 1'b1;
      clearq();
      repeat (10) step(0);
      chk("t3_words", dq.size(), 5);
      for (int i = 0; i < 5; i++) chk("t3_order", dq[i], 32'hA0 + i);
      chk("t3_span", dcyc[4] - dcyc[0], 4);
      // wrap across a full lap of the address space
      reset_all();
      bus.rd_ready = 1'b1;
      clearq();
      repeat (60) step(20);
      chk("t4_issues", aq.size(), 20);
      for (int i = 0; i < 20; i++) chk("t4_addr", aq[i], i % 16);
      chk("t4_ptr16", p16, 5'b11000);
      chk("t4_ptr_final", bus.rd_ptr, 5'b11110);
      chk("t4_words", dq.size(), 20);
      for (int i = 0; i < 20; i++) chk("t4_data", dq[i], 32'hA0 + i);
      // almost-empty asserts in the same update that lowers the level to the threshold
      reset_all();
      write_to(5);
      repeat (10) step(0);
      chk("t5_level3", bus.rd_level, 3);
      chk("t5_ae0", bus.rd_almost_empty, 0);
      bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      bus.rd_ready = 1'b0;
      chk("t5_level2", bus.rd_level, 2);
      chk("t5_ae1", bus.rd_almost_empty, 1);
      chk("t5_head", bus.rd_data, 8'hA1);
      // reset while the buffer is full and a read is being issued
      reset_all();
      write_to(8);
      repeat (10) step(0);
      chk("t6_full_valid", bus.rd_valid, 1);
      bus.rd_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("t6_issue_in_rst", bus.rd_en_mem, 1);
      wcnt = 0;
      bus.wr_ptr = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_valid", bus.rd_valid, 0);
      chk("t6_ptr", bus.rd_ptr, 0);
      chk("t6_empty", bus.rd_empty, 1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("t6_stale", bus.rd_valid, 0);
      end
      // randomized traffic with varying rates and occasional resets
      rp = 2; wp = 2;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin rp = $urandom_range(1, 4); wp = $urandom_range(1, 4); end
         @(negedge clk);
         @(posedge clk); #1;
         rst = ($urandom_range(0, 599) == 0);
         fl = wcnt[4:0] - b2(bus.rd_ptr);
         if (rst) begin wcnt = 0; bus.wr_ptr = '0; end
         else if ($urandom_range(0, 3) < wp && fl < 5'd16) wr1(8'($urandom));
         bus.rd_ready = ($urandom_range(0, 3) < rp);
      end
      rst = 1'b0;
      bus.rd_ready = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
